// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring radix-2.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  reg_waddr_i,
    output logic [31:0] result_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic [4:0]  reg_waddr_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_CALC  = 2'd2,
        S_END   = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_BIT = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [1:0]  r_op;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic [4:0]  r_waddr;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;
    logic        r_q_neg;
    logic        r_r_neg;

    logic        w_accept;
    logic        w_signed;
    logic        w_rem_op;
    logic [31:0] w_dvd_abs;
    logic [31:0] w_dvs_abs;
    logic [32:0] w_rem_shift;
    logic [31:0] w_diff;
    logic        w_ge;
    logic [31:0] w_q_final;
    logic [31:0] w_r_final;
    logic        w_unused_op;

    // funct3[2] is always set for the divide group; only [1:0] select the op
    assign w_unused_op = op_i[2];

    // A start held through the result cycle must not relaunch
    assign w_accept  = start_i && !ready_o;
    assign w_signed  = ~r_op[0];
    assign w_rem_op  = r_op[1];

    assign w_dvd_abs = (w_signed && r_dividend[31]) ? (~r_dividend + 32'd1) : r_dividend;
    assign w_dvs_abs = (w_signed && r_divisor[31])  ? (~r_divisor + 32'd1)  : r_divisor;

    // 33-bit partial remainder; once accepted the difference always fits in 32 bits
    assign w_rem_shift = {r_rem, r_quot[31]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
    assign w_diff      = w_rem_shift[31:0] - r_divisor;

    assign w_q_final = r_q_neg ? (~r_quot + 32'd1) : r_quot;
    assign w_r_final = r_r_neg ? (~r_rem + 32'd1)  : r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_START;
            end
            S_START: begin
                if (!start_i || (r_divisor == 32'd0)) w_state_nxt = S_IDLE;
                else                                  w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (!start_i)                w_state_nxt = S_IDLE;
                else if (r_cnt == c_LAST_BIT) w_state_nxt = S_END;
            end
            S_END: begin
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_o    <= 32'd0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            reg_waddr_o <= 5'd0;
            r_op        <= 2'd0;
            r_dividend  <= 32'd0;
            r_divisor   <= 32'd0;
            r_waddr     <= 5'd0;
            r_quot      <= 32'd0;
            r_rem       <= 32'd0;
            r_cnt       <= 5'd0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= op_i[1:0];
                        r_dividend <= dividend_i;
                        r_divisor  <= divisor_i;
                        r_waddr    <= reg_waddr_i;
                        busy_o     <= 1'b1;
                    end
                end
                S_START: begin
                    if (!start_i) begin
                        busy_o <= 1'b0;
                    end else if (r_divisor == 32'd0) begin
                        result_o    <= w_rem_op ? r_dividend : 32'hFFFF_FFFF;
                        reg_waddr_o <= r_waddr;
                        ready_o     <= 1'b1;
                        busy_o      <= 1'b0;
                    end else begin
                        r_quot    <= w_dvd_abs;
                        r_divisor <= w_dvs_abs;
                        r_q_neg   <= w_signed && (r_dividend[31] ^ r_divisor[31]);
                        r_r_neg   <= w_signed && r_dividend[31];
                        r_rem     <= 32'd0;
                        r_cnt     <= 5'd0;
                    end
                end
                S_CALC: begin
                    if (!start_i) begin
                        busy_o <= 1'b0;
                    end else begin
                        // Dividend bits shift out of r_quot as quotient bits shift in
                        r_rem  <= w_ge ? w_diff : w_rem_shift[31:0];
                        r_quot <= {r_quot[30:0], w_ge};
                        r_cnt  <= r_cnt + 5'd1;
                    end
                end
                S_END: begin
                    busy_o <= 1'b0;
                    if (start_i) begin
                        result_o    <= w_rem_op ? w_r_final : w_q_final;
                        reg_waddr_o <= r_waddr;
                        ready_o     <= 1'b1;
                    end
                end
                default: busy_o <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Brief    : Randomised self-checking bench for div_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_rd  = 5'd0;

    localparam logic [2:0] c_DIV  = 3'b100;
    localparam logic [2:0] c_DIVU = 3'b101;
    localparam logic [2:0] c_REM  = 3'b110;
    localparam logic [2:0] c_REMU = 3'b111;

    div_unit u_dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .reg_waddr_o (reg_waddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V division semantics in 64-bit arithmetic, so INT_MIN / -1 cannot overflow
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) begin
            q = 64'hFFFF_FFFF;
            r = {32'd0, a};
        end else if (op[0] == 1'b0) begin
            x = $signed(a);
            y = $signed(b);
            q = x / y;
            r = x % y;
        end else begin
            x = {32'd0, a};
            y = {32'd0, b};
            q = x / y;
            r = x % y;
        end
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int  lat;
        int  exp_lat;
        bit  seen;
        bit  busy_ok;
        exp_lat = (b == 32'd0) ? 1 : 34;
        @(negedge clk);
        start_i     = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = rd;
        seen    = 1'b0;
        busy_ok = 1'b1;
        lat     = -1;
        for (int e = 0; e < 60 && !seen; e++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                seen = 1'b1;
                lat  = e;
            end else if (!busy_o) begin
                busy_ok = 1'b0;
            end
            // Captured operands must be immune to later input changes
            dividend_i  = $urandom;
            divisor_i   = $urandom;
            reg_waddr_i = 5'($urandom);
            op_i        = 3'b100 | 3'($urandom_range(0, 3));
        end
        check({tag, " ready_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " latency"}, 32'(lat), 32'(exp_lat));
            check({tag, " result"}, result_o, exp);
            check({tag, " waddr"}, 32'(reg_waddr_o), 32'(rd));
            check({tag, " busy_clear"}, 32'(busy_o), 32'd0);
            check({tag, " busy_during"}, 32'(busy_ok), 32'd1);
            last_res = exp;
            last_rd  = rd;
            // start still high across the result cycle
            @(posedge clk);
            #1;
            check({tag, " no_relaunch"}, {30'd0, busy_o, ready_o}, 32'd0);
        end
        start_i = 1'b0;
    endtask

    task automatic do_abort();
        bit busy_ok;
        bit ready_seen;
        busy_ok    = 1'b1;
        ready_seen = 1'b0;
        @(negedge clk);
        start_i     = 1'b1;
        op_i        = c_DIVU;
        dividend_i  = 32'd1000;
        divisor_i   = 32'd3;
        reg_waddr_i = 5'd29;
        for (int e = 0; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (!busy_o) busy_ok = 1'b0;
            if (ready_o) ready_seen = 1'b1;
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy_before", 32'(busy_ok), 32'd1);
        check("abort busy_drop", 32'(busy_o), 32'd0);
        check("abort result_kept", result_o, last_res);
        check("abort waddr_kept", 32'(reg_waddr_o), 32'(last_rd));
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (ready_o) ready_seen = 1'b1;
        end
        check("abort no_ready", 32'(ready_seen), 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        rst         = 1'b0;
        start_i     = 1'b0;
        op_i        = c_DIV;
        dividend_i  = 32'd0;
        divisor_i   = 32'd0;
        reg_waddr_i = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result_o, 32'd0);
        check("reset flags", {30'd0, busy_o, ready_o}, 32'd0);
        check("reset waddr", 32'(reg_waddr_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        do_op("divu_100_7",   c_DIVU, 32'd100,        32'd7,          5'd5,  32'd14);
        do_op("rem_m7_2",     c_REM,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF);
        do_op("div_m7_2",     c_DIV,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD);
        do_op("div_5_0",      c_DIV,  32'd5,          32'd0,          5'd8,  32'hFFFF_FFFF);
        do_op("remu_1234_0",  c_REMU, 32'h0000_1234,  32'd0,          5'd9,  32'h0000_1234);
        do_op("div_ovf",      c_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000);
        do_op("rem_ovf",      c_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h0000_0000);

        do_abort();

        for (int i = 0; i < 40; i++) begin
            op  = 3'b100 | 3'($urandom_range(0, 3));
            a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 32'd0;
            else if (sel < 4)  b = 32'($urandom_range(1, 15));
            else if (sel == 4) b = 32'hFFFF_FFFF;
            else               b = $urandom;
            do_op($sformatf("rand%0d", i), op, a, b, 5'($urandom), ref_div(op, a, b));
        end

        // Asynchronous reset between clock edges in the middle of a division
        @(negedge clk);
        start_i     = 1'b1;
        op_i        = c_DIVU;
        dividend_i  = 32'd77777;
        divisor_i   = 32'd13;
        reg_waddr_i = 5'd17;
        repeat (15) @(posedge clk);
        #3;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("async_rst result", result_o, 32'd0);
        check("async_rst flags", {30'd0, busy_o, ready_o}, 32'd0);
        check("async_rst waddr", 32'(reg_waddr_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_op("post_rst_divu_9_3", c_DIVU, 32'd9, 32'd3, 5'd3, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider on the consumer side of the ID/EX pipeline register.
- The EX stage forwards decoded DIV/DIVU/REM/REMU operands from the ID/EX register outputs into this block.
- While the block is busy, EX raises a hold request so the hold controller freezes IF/ID and flushes ID/EX.
- The block returns the result and destination register address with a one-cycle ready pulse; EX then writes back.

Parameters:
None (datapath width fixed at 32 bits; register address width fixed at 5 bits).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
start_i  input  1  division request; held high by EX until ready_o or flush
op_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
dividend_i  input  32  rs1 value
divisor_i  input  32  rs2 value
reg_waddr_i  input  5  destination register
result_o  output  32  quotient or remainder
ready_o  output  1  one-cycle result-valid pulse
busy_o  output  1  operation in progress; EX converts to hold request
reg_waddr_o  output  5  destination register captured at start

Behaviour:
- Reset (rst low, async):
  - state=IDLE.
  - result_o=0, ready_o=0, busy_o=0, reg_waddr_o=0.
  - Internal counter and operand registers cleared.
- Outputs are all registered. ready_o defaults to 0 every edge unless set below.
- IDLE:
  - If start_i=1 and ready_o=0: latch op, dividend, divisor, waddr; busy_o<=1; go to START.
  - start_i=1 while ready_o=1 (the result cycle) is ignored, so a held start does not relaunch.
- START:
  - divisor==0: quotient=0xFFFFFFFF, remainder=dividend (no trap). Load result_o per op; ready_o<=1; busy_o<=0; go to IDLE.
  - Otherwise:
    - Signed ops (DIV, REM): load |dividend| and |divisor| as unsigned.
    - Record quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
    - Clear partial remainder and counter; go to CALC.
- CALC:
  - Restoring shift-subtract, one quotient bit per edge, MSB first, over a 33-bit partial remainder.
  - Exactly 32 edges; on the 32nd edge go to END.
- END:
  - Apply signs: negate quotient if quotient sign set; negate remainder if remainder sign set; signs ignored for DIVU/REMU.
  - result_o<=quotient (DIV/DIVU) or remainder (REM/REMU); ready_o<=1; busy_o<=0; go to IDLE.
- Latency, with start sampled at edge E0:
  - Normal: ready_o high in the cycle after E34.
  - Divide-by-zero: ready_o high in the cycle after E1.
- Overflow (0x80000000 / 0xFFFFFFFF, DIV/REM) needs no special case: quotient=0x80000000, remainder=0.
- Abort:
  - start_i=0 sampled in START, CALC or END → IDLE next edge; busy_o<=0; ready_o stays 0; result_o and reg_waddr_o unchanged.
  - Covers jump flush.
- Operand inputs are ignored after capture; changing them mid-operation has no effect.
- result_o and reg_waddr_o hold their last values until the next completion.
- Reset mid-operation: immediate return to reset values; no ready_o pulse.

Test Plan:
- DIVU 100/7: start held until ready → ready_o pulse exactly 34 edges after acceptance; result_o=14; reg_waddr_o=captured rd; busy_o high during edges 1..34.
- REM 0xFFFFFFF9(-7) / 2 → result_o=0xFFFFFFFF. DIV same operands → 0xFFFFFFFD (-3).
- Divide-by-zero:
  - DIV 5/0 → 0xFFFFFFFF after 1 edge.
  - REMU 0x1234/0 → 0x1234.
  - busy_o pulses for one cycle only.
- Overflow DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0x00000000.
- Abort and hold behaviour:
  - Drop start_i at edge 10 of CALC → IDLE next edge, busy_o=0, no ready_o pulse, result_o keeps previous value.
  - start_i held through the ready cycle → no second launch.
- Async reset:
  - Assert rst low mid-CALC between clock edges → outputs 0 immediately.
  - After release, a new DIVU 9/3 → 3 with normal 34-edge latency.
